// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper.
package truth_pkg;

  localparam int N_IN   = 3;
  localparam int ROWS   = 2 ** N_IN;
  localparam int N_FUNC = 4;

  // Bit positions of the four sampled functions within f_in.
  localparam int F_SOPC = 0;
  localparam int F_POSC = 1;
  localparam int F_SOPD = 2;
  localparam int F_POSD = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Bundle of stimulus/capture signals between the sweeper and its user.
interface truth_table_sweeper_if;
  import truth_pkg::*;

  logic                  start;
  logic [N_IN-1:0]       xyz;
  logic [N_FUNC-1:0]     f_in;
  logic                  busy;
  logic                  done;
  logic [ROWS-1:0]       tt_sopc;
  logic [ROWS-1:0]       tt_posc;
  logic [ROWS-1:0]       tt_sopd;
  logic [ROWS-1:0]       tt_posd;
  logic                  match_c;
  logic                  match_d;
  logic [ROWS-1:0]       diff_c;
  logic [ROWS-1:0]       diff_d;
  logic [7:0]            pass_count;

  // Side that requests sweeps and evaluates the function block.
  modport master (
    output start, f_in,
    input  xyz, busy, done, tt_sopc, tt_posc, tt_sopd, tt_posd,
           match_c, match_d, diff_c, diff_d, pass_count
  );

  // The sweeper itself.
  modport slave (
    input  start, f_in,
    output xyz, busy, done, tt_sopc, tt_posc, tt_sopd, tt_posd,
           match_c, match_d, diff_c, diff_d, pass_count
  );
endinterface

// File: rtl/truth_table_sweeper_row_counter.sv
// Row index register: clear, count enable, and a flag on the last row.
module row_counter
  import truth_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [N_IN-1:0] idx_o,
  output logic            last_o
);

  logic [N_IN-1:0] idx_q;

  // Index register; counting past the last row wraps naturally to 0.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     idx_q <= '0;
    else if (clr_i) idx_q <= '0;
    else if (en_i)  idx_q <= idx_q + 1'b1;
  end

  assign idx_o  = idx_q;
  assign last_o = (idx_q == N_IN'(ROWS - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Steps the 3-bit row index through all rows, captures four function
// outputs into truth tables and compares the SoP/PoS pairs.
module truth_table_sweeper
  import truth_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  truth_table_sweeper_if.slave bus
);

  state_e                      state_q, state_d;
  logic [N_FUNC-1:0][ROWS-1:0] tt_q, tt_d;
  logic                        match_c_q, match_c_d;
  logic                        match_d_q, match_d_d;
  logic [7:0]                  pass_q, pass_d;
  logic                        cnt_clr, cnt_en;
  logic [N_IN-1:0]             idx;
  logic                        last;

  row_counter u_row_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .idx_o  (idx),
    .last_o (last)
  );

  // Next state, table capture, match evaluation and pass counting.
  // NOTE: every signal gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    tt_d      = tt_q;
    match_c_d = match_c_q;
    match_d_d = match_d_q;
    pass_d    = pass_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = SWEEP;
          cnt_clr   = 1'b1;
          tt_d      = '0;
          match_c_d = 1'b0;
          match_d_d = 1'b0;
        end
      end
      SWEEP: begin
        cnt_en = 1'b1;
        for (int f = 0; f < N_FUNC; f++) tt_d[f][idx] = bus.f_in[f];
        if (last) begin
          // Compare using the tables that include the row being captured now.
          state_d   = DONE;
          match_c_d = (tt_d[F_SOPC] == tt_d[F_POSC]);
          match_d_d = (tt_d[F_SOPD] == tt_d[F_POSD]);
        end
      end
      DONE: begin
        state_d = IDLE;
        if (match_c_q && match_d_q) pass_d = pass_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, tables, flags and pass counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tt_q      <= '0;
      match_c_q <= 1'b0;
      match_d_q <= 1'b0;
      pass_q    <= '0;
    end else begin
      state_q   <= state_d;
      tt_q      <= tt_d;
      match_c_q <= match_c_d;
      match_d_q <= match_d_d;
      pass_q    <= pass_d;
    end
  end

  assign bus.xyz        = (state_q == SWEEP) ? idx : '0;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.tt_sopc    = tt_q[F_SOPC];
  assign bus.tt_posc    = tt_q[F_POSC];
  assign bus.tt_sopd    = tt_q[F_SOPD];
  assign bus.tt_posd    = tt_q[F_POSD];
  assign bus.match_c    = match_c_q;
  assign bus.match_d    = match_d_q;
  assign bus.diff_c     = tt_q[F_SOPC] ^ tt_q[F_POSC];
  assign bus.diff_d     = tt_q[F_SOPD] ^ tt_q[F_POSD];
  assign bus.pass_count = pass_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: a table-driven function block feeds the sweeper and
// a minterm-level reference model predicts tables, flags and pass count.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  truth_table_sweeper_if bus_if ();

  truth_table_sweeper dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Function block: each output is its own 8-row truth table indexed by xyz.
  logic [7:0] fn_tab [4];
  assign bus_if.f_in = {fn_tab[3][bus_if.xyz], fn_tab[2][bus_if.xyz],
                        fn_tab[1][bus_if.xyz], fn_tab[0][bus_if.xyz]};

  localparam logic [7:0] GOLD_C = 8'hD5;  // minterms 0,2,4,6,7
  localparam logic [7:0] GOLD_D = 8'hCF;  // minterms 0,1,2,3,6,7

  int         n_vec  = 0;
  int         n_fail = 0;
  logic [7:0] exp_pass = 8'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " xyz"},  32'(bus_if.xyz), 0);
    check({tag, " busy"}, 32'(bus_if.busy), 0);
    check({tag, " done"}, 32'(bus_if.done), 0);
    check({tag, " tt"},   {bus_if.tt_sopc, bus_if.tt_posc, bus_if.tt_sopd, bus_if.tt_posd}, 0);
    check({tag, " match"}, {30'd0, bus_if.match_c, bus_if.match_d}, 0);
    check({tag, " diff"}, {16'd0, bus_if.diff_c, bus_if.diff_d}, 0);
    check({tag, " pass"}, 32'(bus_if.pass_count), 0);
  endtask

  // One full sweep from IDLE with the given function tables; checks timing
  // and results against the model. Returns at #1 after the edge leaving DONE.
  task automatic run_sweep(input logic [7:0] sc, input logic [7:0] pc,
                           input logic [7:0] sd, input logic [7:0] pd);
    logic mc, md;
    fn_tab[0] = sc; fn_tab[1] = pc; fn_tab[2] = sd; fn_tab[3] = pd;
    mc = (sc == pc);
    md = (sd == pd);
    if (mc && md) exp_pass = exp_pass + 8'd1;
    @(negedge clk);
    bus_if.start = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    check("busy after accept", 32'(bus_if.busy), 1);
    for (int r = 0; r < 8; r++) begin
      check("xyz step", 32'(bus_if.xyz), 32'(r));
      check("no early done", 32'(bus_if.done), 0);
      @(posedge clk);
      #1;
    end
    check("done pulse", 32'(bus_if.done), 1);
    check("tt_sopc", 32'(bus_if.tt_sopc), 32'(sc));
    check("tt_posc", 32'(bus_if.tt_posc), 32'(pc));
    check("tt_sopd", 32'(bus_if.tt_sopd), 32'(sd));
    check("tt_posd", 32'(bus_if.tt_posd), 32'(pd));
    check("diff_c", 32'(bus_if.diff_c), 32'(sc ^ pc));
    check("diff_d", 32'(bus_if.diff_d), 32'(sd ^ pd));
    check("match_c", 32'(bus_if.match_c), 32'(mc));
    check("match_d", 32'(bus_if.match_d), 32'(md));
    @(posedge clk);
    #1;
    check("done one cycle", 32'(bus_if.done), 0);
    check("idle busy", 32'(bus_if.busy), 0);
    check("pass_count", 32'(bus_if.pass_count), 32'(exp_pass));
    check("results hold", 32'(bus_if.tt_posc), 32'(pc));
  endtask

  initial begin
    int done_cycles[$];
    logic [7:0] a, b;

    bus_if.start = 1'b0;
    fn_tab[0] = GOLD_C; fn_tab[1] = GOLD_C; fn_tab[2] = GOLD_D; fn_tab[3] = GOLD_D;

    // Reset held, then released with no start: everything stays at zero.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("in reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      check("idle quiet", {bus_if.xyz, bus_if.busy, bus_if.done, bus_if.pass_count}, 0);
    end

    // Golden SoP/PoS evaluator.
    run_sweep(GOLD_C, GOLD_C, GOLD_D, GOLD_D);
    check("first pass_count", 32'(bus_if.pass_count), 1);

    // Fault: pos_c forced to 1 on row 5.
    run_sweep(GOLD_C, GOLD_C | 8'h20, GOLD_D, GOLD_D);
    check("fault diff_c", 32'(bus_if.diff_c), 32'h20);
    check("fault pass held", 32'(bus_if.pass_count), 1);

    // Start held high: one sweep every 10 cycles, nothing queued.
    fn_tab[0] = GOLD_C; fn_tab[1] = GOLD_C; fn_tab[2] = GOLD_D; fn_tab[3] = GOLD_D;
    @(negedge clk);
    bus_if.start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus_if.done) begin
        done_cycles.push_back(c);
        exp_pass = exp_pass + 8'd1;
        @(negedge clk);
        check("held start pass_count", 32'(bus_if.pass_count), 32'(exp_pass - 8'd1));
      end
    end
    bus_if.start = 1'b0;
    check("held start sweeps", 32'(done_cycles.size()), 4);
    for (int i = 1; i < done_cycles.size(); i++)
      check("sweep period", 32'(done_cycles[i] - done_cycles[i-1]), 10);
    @(posedge clk);
    #1;
    check("held start pass total", 32'(bus_if.pass_count), 32'(exp_pass));
    check("held start idle", 32'(bus_if.busy), 0);

    // Asynchronous reset while idx=4.
    @(negedge clk);
    bus_if.start = 1'b1;
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre-reset xyz", 32'(bus_if.xyz), 4);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid-sweep reset");
    exp_pass = 8'd0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("no done in reset", 32'(bus_if.done), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep(GOLD_C, GOLD_C, GOLD_D, GOLD_D);

    // Randomized tables; pairs are forced equal half of the time.
    for (int s = 0; s < 20; s++) begin
      a = 8'($urandom);
      b = ($urandom_range(1) == 1) ? a : 8'($urandom);
      fn_tab[0] = 8'($urandom);
      run_sweep(a, b, fn_tab[0], ($urandom_range(1) == 1) ? fn_tab[0] : 8'($urandom));
      repeat ($urandom_range(3)) @(posedge clk);
      #1;
    end

    // Enough passing sweeps to carry pass_count through 255 -> 0.
    for (int s = 0; s < 256; s++) run_sweep(GOLD_C, GOLD_C, GOLD_D, GOLD_D);
    check("wrap total", 32'(bus_if.pass_count), 32'(exp_pass));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
